// File: rtl/servo_pwm_scheduler_if.sv
// Command and PWM bundle between servo sequencers and the PWM scheduler.
// Requesters hold ServoNum/ActiveServoDuty; the scheduler drives the pulses.
interface servo_pwm_scheduler_if;
  logic        EnableScheduler;
  logic [1:0]  ServoNum;
  logic [20:0] ActiveServoDuty;
  logic [3:0]  PWM;
  logic        ActivePeriodFinished;
  logic [7:0]  FrameCount;

  modport master (
    output EnableScheduler,
    output ServoNum,
    output ActiveServoDuty,
    input  PWM,
    input  ActivePeriodFinished,
    input  FrameCount
  );

  modport slave (
    input  EnableScheduler,
    input  ServoNum,
    input  ActiveServoDuty,
    output PWM,
    output ActivePeriodFinished,
    output FrameCount
  );
endinterface

// File: rtl/servo_pwm_scheduler.sv
// servo_pwm_scheduler: one frame timer driving four servo PWM lines.
// Duty commands commit only at frame boundaries so pulses never glitch.
module servo_pwm_scheduler #(
  parameter int unsigned PERIOD     = 2_000_000,
  parameter int unsigned DUTY_MIN   = 50_000,
  parameter int unsigned DUTY_MAX   = 250_000,
  parameter int unsigned DUTY_RESET = 150_000
) (
  input logic                  clk,
  input logic                  ResetServoScheduler,
  servo_pwm_scheduler_if.slave bus
);

  localparam logic [20:0] LAST = 21'(PERIOD - 1);
  localparam logic [20:0] DMIN = 21'(DUTY_MIN);
  localparam logic [20:0] DMAX = 21'(DUTY_MAX);
  localparam logic [20:0] DRST = 21'(DUTY_RESET);

  logic [20:0] cnt;
  logic [20:0] duty [4];
  logic [3:0]  pwm_q;
  logic        apf_q;
  logic [7:0]  frames_q;
  logic        frame_end;
  logic [20:0] duty_req;

  assign frame_end = bus.EnableScheduler && (cnt == LAST);

  always_comb begin
    duty_req = bus.ActiveServoDuty;
    unique case (1'b1)
      (bus.ActiveServoDuty < DMIN): duty_req = DMIN;
      (bus.ActiveServoDuty > DMAX): duty_req = DMAX;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ResetServoScheduler) begin
      cnt      <= '0;
      pwm_q    <= '0;
      apf_q    <= 1'b0;
      frames_q <= '0;
      for (int i = 0; i < 4; i++)
        duty[i] <= DRST;
    end else begin
      apf_q <= frame_end;
      if (!bus.EnableScheduler || frame_end)
        cnt <= '0;
      else
        cnt <= cnt + 21'd1;
      for (int i = 0; i < 4; i++)
        pwm_q[i] <= bus.EnableScheduler && (cnt < duty[i]);
      // the new duty is first compared against cnt=0 of the next frame
      if (frame_end) begin
        frames_q           <= frames_q + 8'd1;
        duty[bus.ServoNum] <= duty_req;
      end
    end
  end

  assign bus.PWM                  = pwm_q;
  assign bus.ActivePeriodFinished = apf_q;
  assign bus.FrameCount           = frames_q;

  param_legal: assert property (@(posedge clk)
    (PERIOD > 1) && (DUTY_MAX < PERIOD));

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Scoreboard bench for servo_pwm_scheduler: per-frame high-time,
// frame pulse and frame count checked against a bench-side model.
module tb_servo_pwm_scheduler;

  localparam int PER  = 1000;
  localparam int DMIN = 50;
  localparam int DMAX = 250;
  localparam int DRST = 150;
  localparam int PER2 = 8;

  typedef struct packed {
    logic [3:0][9:0] hi;
    logic [7:0]      fc;
    logic            pulse_ok;
  } frame_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [20:0] model_duty [4];
  logic [7:0]  model_fc;
  frame_t      exp_q [$];
  frame_t      obs_q [$];

  servo_pwm_scheduler_if bus ();
  servo_pwm_scheduler_if bus2 ();

  servo_pwm_scheduler #(
    .PERIOD(PER), .DUTY_MIN(DMIN),
    .DUTY_MAX(DMAX), .DUTY_RESET(DRST)
  ) dut (
    .clk(clk),
    .ResetServoScheduler(rst),
    .bus(bus)
  );

  servo_pwm_scheduler #(
    .PERIOD(PER2), .DUTY_MIN(1),
    .DUTY_MAX(3), .DUTY_RESET(2)
  ) dut2 (
    .clk(clk),
    .ResetServoScheduler(rst),
    .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] clamp(input logic [20:0] d);
    if (d < 21'(DMIN)) return 21'(DMIN);
    if (d > 21'(DMAX)) return 21'(DMAX);
    return d;
  endfunction

  function automatic string fmt(input frame_t f);
    return $sformatf("hi=%0d/%0d/%0d/%0d fc=%0d pulse_ok=%0b",
      f.hi[0], f.hi[1], f.hi[2], f.hi[3], f.fc, f.pulse_ok);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_duty[i] = 21'(DRST);
    model_fc = '0;
  endtask

  // Run one full frame starting right after a frame boundary.
  task automatic run_frame(input int chg_at,
                           input logic [1:0] chg_sn,
                           input logic [20:0] chg_duty);
    frame_t e;
    frame_t o;
    e = '0;
    for (int i = 0; i < 4; i++) e.hi[i] = 10'(model_duty[i]);
    e.fc = model_fc + 8'd1;
    e.pulse_ok = 1'b1;
    exp_q.push_back(e);
    o = '0;
    o.pulse_ok = 1'b1;
    for (int s = 1; s <= PER; s++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (bus.PWM[i] === 1'b1) o.hi[i] = o.hi[i] + 10'd1;
      if (bus.ActivePeriodFinished !== (s == PER)) o.pulse_ok = 1'b0;
      if (s == chg_at) begin
        bus.ServoNum = chg_sn;
        bus.ActiveServoDuty = chg_duty;
      end
    end
    o.fc = bus.FrameCount;
    obs_q.push_back(o);
    model_duty[bus.ServoNum] = clamp(bus.ActiveServoDuty);
    model_fc = model_fc + 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.EnableScheduler = 1'b0;
    bus.ServoNum = 2'd0;
    bus.ActiveServoDuty = 21'(DRST);
    bus2.EnableScheduler = 1'b0;
    bus2.ServoNum = 2'd0;
    bus2.ActiveServoDuty = 21'd2;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.PWM !== 4'b0 || bus.ActivePeriodFinished !== 1'b0 ||
        bus.FrameCount !== 8'd0) begin
      miscompares++;
      $display("FAIL reset: got pwm=%b apf=%b fc=%0d want 0000/0/0",
        bus.PWM, bus.ActivePeriodFinished, bus.FrameCount);
    end
    vectors++;
    if (bus2.PWM !== 4'b0 || bus2.FrameCount !== 8'd0) begin
      miscompares++;
      $display("FAIL reset2: got pwm=%b fc=%0d want 0000/0",
        bus2.PWM, bus2.FrameCount);
    end
    bus.EnableScheduler = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (bus.PWM !== 4'b0 || bus.ActivePeriodFinished !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_with_enable: got pwm=%b apf=%b want 0000/0",
          bus.PWM, bus.ActivePeriodFinished);
      end
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    frame_t e;
    frame_t o;
    repeat (3) run_frame(-1, 2'd0, 21'd0);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL basic: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_commit();
    frame_t e;
    frame_t o;
    bus.ServoNum = 2'd2;
    bus.ActiveServoDuty = 21'd60;
    run_frame(-1, 2'd0, 21'd0);
    run_frame(400, 2'd2, 21'd240);
    run_frame(-1, 2'd0, 21'd0);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL commit: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_clamp();
    frame_t e;
    frame_t o;
    logic [1:0]  sn [4];
    logic [20:0] dv [4];
    sn = '{2'd0, 2'd1, 2'd3, 2'd2};
    dv = '{21'd10, 21'd0, 21'd2000, 21'd250};
    for (int k = 0; k < 4; k++) begin
      bus.ServoNum = sn[k];
      bus.ActiveServoDuty = dv[k];
      run_frame(-1, 2'd0, 21'd0);
    end
    run_frame(-1, 2'd0, 21'd0);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL clamp: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_disable();
    frame_t e;
    frame_t o;
    repeat (100) @(negedge clk);
    bus.EnableScheduler = 1'b0;
    repeat (20) begin
      @(negedge clk);
      vectors++;
      if (bus.PWM !== 4'b0 || bus.ActivePeriodFinished !== 1'b0 ||
          bus.FrameCount !== model_fc) begin
        miscompares++;
        $display("FAIL disable_idle: got pwm=%b apf=%b fc=%0d want 0000/0/%0d",
          bus.PWM, bus.ActivePeriodFinished, bus.FrameCount, model_fc);
      end
    end
    bus.EnableScheduler = 1'b1;
    run_frame(-1, 2'd0, 21'd0);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL disable_resume: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    frame_t e;
    frame_t o;
    bus.ServoNum = 2'd1;
    bus.ActiveServoDuty = 21'd80;
    run_frame(-1, 2'd0, 21'd0);
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.PWM !== 4'b0 || bus.ActivePeriodFinished !== 1'b0 ||
        bus.FrameCount !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got pwm=%b apf=%b fc=%0d want 0000/0/0",
        bus.PWM, bus.ActivePeriodFinished, bus.FrameCount);
    end
    rst = 1'b0;
    model_reset();
    run_frame(-1, 2'd0, 21'd0);
    run_frame(-1, 2'd0, 21'd0);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_mid_frame: got %s want %s", fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_wrap();
    int waited;
    logic [7:0] want;
    bus.EnableScheduler = 1'b0;
    bus2.EnableScheduler = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      want = 8'(k);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (bus2.ActivePeriodFinished !== 1'b1 && waited < 4 * PER2);
      vectors++;
      if (bus2.ActivePeriodFinished !== 1'b1 || bus2.FrameCount !== want) begin
        miscompares++;
        $display("FAIL wrap pulse %0d: got apf=%b fc=%0d want apf=1 fc=%0d",
          k, bus2.ActivePeriodFinished, bus2.FrameCount, want);
      end
    end
    bus2.EnableScheduler = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_commit();
    test_clamp();
    test_disable();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
